// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO iterative divider.
package hilo_div_pkg;

  localparam int unsigned StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StCalc,
    StSign,
    StDone
  } divState_e;

  // Replicated to WIDTH bits to form the all-ones divide-by-zero quotient.
  localparam logic DivZeroFill = 1'b1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] dvsMag,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder never reaches the divisor, so it is stored in WIDTH bits;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    diff    = shifted - {1'b0, dvsMag};
    if (!diff[WIDTH]) begin
      remOut = diff[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end else begin
      remOut = shifted[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Iterative signed/unsigned divider producing LO (quotient) and HI (remainder).
module hilo_divider
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntWidth = $clog2(WIDTH + 1);
  localparam logic [CntWidth-1:0] LastStep = CntWidth'(WIDTH - 1);

  divState_e stateQ, stateD;
  logic [CntWidth-1:0] cntQ, cntD;
  logic [WIDTH-1:0] remQ, remD;
  logic [WIDTH-1:0] quoQ, quoD;
  logic [WIDTH-1:0] dvsQ, dvsD;
  logic quoNegQ, quoNegD;
  logic remNegQ, remNegD;
  logic [WIDTH-1:0] quotientD, remainderD;
  logic divByZeroD;

  logic dvdNeg, dvsNeg;
  logic [WIDTH-1:0] dvdMag, dvsMag;
  logic [WIDTH-1:0] stepRem, stepQuo;

  div_step #(
    .WIDTH (WIDTH)
  ) uStep (
    .remIn  (remQ),
    .quoIn  (quoQ),
    .dvsMag (dvsQ),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

  always_comb begin
    dvdNeg = signed_div & dividend[WIDTH-1];
    dvsNeg = signed_div & divisor[WIDTH-1];
    dvdMag = dvdNeg ? -dividend : dividend;
    dvsMag = dvsNeg ? -divisor : divisor;
  end

  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    remD        = remQ;
    quoD        = quoQ;
    dvsD        = dvsQ;
    quoNegD     = quoNegQ;
    remNegD     = remNegQ;
    quotientD   = quotient;
    remainderD  = remainder;
    divByZeroD  = div_by_zero;

    unique case (stateQ)
      StIdle, StDone: begin
        stateD = StIdle;
        if (start) begin
          remD    = '0;
          quoD    = dvdMag;
          dvsD    = dvsMag;
          quoNegD = dvdNeg ^ dvsNeg;
          remNegD = dvdNeg;
          cntD    = '0;
          if (divisor == '0) begin
            stateD     = StDone;
            quotientD  = {WIDTH{DivZeroFill}};
            remainderD = dividend;
            divByZeroD = 1'b1;
          end else begin
            stateD = StCalc;
          end
        end
      end
      StCalc: begin
        remD = stepRem;
        quoD = stepQuo;
        cntD = cntQ + 1'b1;
        if (cntQ == LastStep) begin
          stateD = StSign;
        end
      end
      StSign: begin
        quotientD  = quoNegQ ? -quoQ : quoQ;
        remainderD = remNegQ ? -remQ : remQ;
        divByZeroD = 1'b0;
        stateD     = StDone;
      end
      default: stateD = StIdle;
    endcase

    // A flush aborts without touching the architectural results.
    if (cancel) begin
      stateD     = StIdle;
      quotientD  = quotient;
      remainderD = remainder;
      divByZeroD = div_by_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= StIdle;
      cntQ        <= '0;
      remQ        <= '0;
      quoQ        <= '0;
      dvsQ        <= '0;
      quoNegQ     <= 1'b0;
      remNegQ     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      remQ        <= remD;
      quoQ        <= quoD;
      dvsQ        <= dvsD;
      quoNegQ     <= quoNegD;
      remNegQ     <= remNegD;
      quotient    <= quotientD;
      remainder   <= remainderD;
      div_by_zero <= divByZeroD;
    end
  end

  assign busy = (stateQ == StCalc) || (stateQ == StSign);
  assign done = (stateQ == StDone);

endmodule
